// File: rtl/counter_pkg.sv
// Shared definitions for the up/down modulo counter.
// Holds the direction encoding, the terminal-value calculation and the
// load-value reduction helper used by counter and counter_step.
package counter_pkg;

  // Direction encoding for the 'up' input.
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Widest counter supported; all helpers work in this width.
  localparam int unsigned MAX_WIDTH = 64;

  // Largest value the counter may hold: MOD-1, or all ones when MOD is 0.
  function automatic logic [MAX_WIDTH-1:0] calc_top(input int unsigned n,
                                                    input logic [MAX_WIDTH-1:0] mod);
    logic [MAX_WIDTH-1:0] all_ones;
    all_ones = {MAX_WIDTH{1'b1}} >> (MAX_WIDTH - n);
    if (mod == '0) begin
      return all_ones;
    end
    return mod - 1'b1;
  endfunction

  // Folds a parallel-load value into range; only values at or above a
  // nonzero modulus are changed.
  function automatic logic [MAX_WIDTH-1:0] mod_reduce(input logic [MAX_WIDTH-1:0] val,
                                                      input logic [MAX_WIDTH-1:0] mod);
    if ((mod != '0) && (val >= mod)) begin
      return val % mod;
    end
    return val;
  endfunction

endpackage

// File: rtl/counter_step.sv
// Combinational step function of the counter.
// Given the current count, direction and terminal value, produces the next
// count and whether that step wraps around (TOP->0 going up, 0->TOP going down).
module counter_step
  import counter_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] cur,
  input  logic         up,
  input  logic [N-1:0] top,
  output logic [N-1:0] next_val,
  output logic         wrap_flag
);

  // Next value and wrap detection; the wrap cases replace the plain +/-1.
  always_comb begin
    next_val  = cur;
    wrap_flag = 1'b0;
    if (up == DIR_UP) begin
      if (cur == top) begin
        next_val  = '0;
        wrap_flag = 1'b1;
      end else begin
        next_val  = cur + 1'b1;
      end
    end else begin
      if (cur == '0) begin
        next_val  = top;
        wrap_flag = 1'b1;
      end else begin
        next_val  = cur - 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter.sv
// Up/down modulo counter with registered wrap pulse and combinational
// terminal-count flag.
// Optional feature: define COUNTER_LOAD_EN to add the load/load_val
// parallel-load ports; without it, load is treated as never asserted.
// Edge priority is reset, then load, then count enable.
module counter
  import counter_pkg::*;
#(
  parameter int          N   = 32,
  parameter logic [63:0] MOD = 64'd0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         up,
`ifdef COUNTER_LOAD_EN
  input  logic         load,
  input  logic [N-1:0] load_val,
`endif
  output logic [N-1:0] dout,
  output logic         wrap,
  output logic         tc
);

  localparam logic [MAX_WIDTH-1:0] TOP_FULL = calc_top(N, MOD);
  localparam logic [N-1:0]         TOP      = TOP_FULL[N-1:0];

  logic         load_i;
  logic [N-1:0] load_val_i;
  logic [MAX_WIDTH-1:0] load_wide;
  logic [MAX_WIDTH-1:0] load_reduced;
  logic [N-1:0] load_next;
  logic [N-1:0] step_next;
  logic         step_wrap;

`ifdef COUNTER_LOAD_EN
  assign load_i     = load;
  assign load_val_i = load_val;
`else
  assign load_i     = 1'b0;
  assign load_val_i = '0;
`endif

  // Bring the load value into range so dout never exceeds TOP.
  assign load_wide    = MAX_WIDTH'(load_val_i);
  assign load_reduced = mod_reduce(load_wide, MOD);
  assign load_next    = load_reduced[N-1:0];

  counter_step #(
    .N(N)
  ) u_step (
    .cur      (dout),
    .up       (up),
    .top      (TOP),
    .next_val (step_next),
    .wrap_flag(step_wrap)
  );

  // Count register and wrap pulse: reset, then load, then step; idle clears wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= '0;
      wrap <= 1'b0;
    end else if (load_i) begin
      dout <= load_next;
      wrap <= 1'b0;
    end else if (en) begin
      dout <= step_next;
      wrap <= step_wrap;
    end else begin
      wrap <= 1'b0;
    end
  end

  // Terminal count: the next enabled step in the current direction would wrap.
  assign tc = en & (((up == DIR_UP) & (dout == TOP)) |
                    ((up == DIR_DOWN) & (dout == '0)));

endmodule

// File: tb/tb_counter.sv
// Scoreboard bench for counter: four instances cover the N/MOD
// configurations; stimulus pushes expected (dout, wrap, tc) into a queue
// and a monitor pops and compares after each clock edge.
module tb_counter;

  typedef struct {
    int          id;
    logic [63:0] dout;
    logic        wrap;
    logic        tc;
    string       name;
  } sb_entry_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en  = 1'b0;
  logic        up  = 1'b1;
  logic        load = 1'b0;
  logic [63:0] load_val = '0;

  logic [31:0] dout0;
  logic [3:0]  dout1;
  logic [3:0]  dout2;
  logic [7:0]  dout3;
  logic        wrap0, wrap1, wrap2, wrap3;
  logic        tc0, tc1, tc2, tc3;

  sb_entry_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  counter #(.N(32), .MOD(64'd0)) u_c32 (
    .clk(clk), .rst(rst), .en(en), .up(up),
`ifdef COUNTER_LOAD_EN
    .load(load), .load_val(load_val[31:0]),
`endif
    .dout(dout0), .wrap(wrap0), .tc(tc0));

  counter #(.N(4), .MOD(64'd0)) u_c4 (
    .clk(clk), .rst(rst), .en(en), .up(up),
`ifdef COUNTER_LOAD_EN
    .load(load), .load_val(load_val[3:0]),
`endif
    .dout(dout1), .wrap(wrap1), .tc(tc1));

  counter #(.N(4), .MOD(64'd10)) u_c10 (
    .clk(clk), .rst(rst), .en(en), .up(up),
`ifdef COUNTER_LOAD_EN
    .load(load), .load_val(load_val[3:0]),
`endif
    .dout(dout2), .wrap(wrap2), .tc(tc2));

  counter #(.N(8), .MOD(64'd100)) u_c100 (
    .clk(clk), .rst(rst), .en(en), .up(up),
`ifdef COUNTER_LOAD_EN
    .load(load), .load_val(load_val[7:0]),
`endif
    .dout(dout3), .wrap(wrap3), .tc(tc3));

  // Drive one cycle of inputs and queue what the chosen instance must show after the edge.
  task automatic applyStimulus(input int id, input logic r, input logic e, input logic u,
                               input logic ld, input logic [63:0] lv,
                               input logic [63:0] exp_dout, input logic exp_wrap,
                               input logic exp_tc, input string nm);
    sb_entry_t ent;
    @(negedge clk);
    rst      = r;
    en       = e;
    up       = u;
    load     = ld;
    load_val = lv;
    ent.id   = id;
    ent.dout = exp_dout;
    ent.wrap = exp_wrap;
    ent.tc   = exp_tc;
    ent.name = nm;
    sb.push_back(ent);
  endtask

  // Compare one popped expectation against the addressed instance.
  task automatic checkOutput(input sb_entry_t ent);
    logic [63:0] a_dout;
    logic        a_wrap;
    logic        a_tc;
    case (ent.id)
      0:       begin a_dout = 64'(dout0); a_wrap = wrap0; a_tc = tc0; end
      1:       begin a_dout = 64'(dout1); a_wrap = wrap1; a_tc = tc1; end
      2:       begin a_dout = 64'(dout2); a_wrap = wrap2; a_tc = tc2; end
      default: begin a_dout = 64'(dout3); a_wrap = wrap3; a_tc = tc3; end
    endcase
    vectors++;
    if (a_dout !== ent.dout || a_wrap !== ent.wrap || a_tc !== ent.tc) begin
      miscompares++;
      $display("[TB] FAIL %s (inst %0d): got dout=%0h wrap=%0b tc=%0b, want dout=%0h wrap=%0b tc=%0b",
               ent.name, ent.id, a_dout, a_wrap, a_tc, ent.dout, ent.wrap, ent.tc);
    end
  endtask

  // Monitor: after each rising edge, settle, then check any pending expectation.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      checkOutput(sb.pop_front());
    end
  end

  initial begin
    // 32-bit full range: reset, count to 10, run on to 0x1234.
    applyStimulus(0, 1, 0, 1, 0, 0, 0, 0, 0, "rst32");
    for (int i = 1; i <= 10; i++)
      applyStimulus(0, 0, 1, 1, 0, 0, 64'(i), 0, 0, "cnt32");
    for (int i = 11; i <= 'h1234; i++)
      applyStimulus(0, 0, 1, 1, 0, 0, 64'(i), 0, 0, "run32");
    // Reset mid-count with en high, then hold at 0, then resume.
    applyStimulus(0, 1, 1, 1, 0, 0, 0, 0, 0, "rst_mid32");
    applyStimulus(0, 1, 1, 0, 0, 0, 0, 0, 1, "rst_tc_down32");
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0, "hold0_a32");
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0, "hold0_b32");
    applyStimulus(0, 0, 1, 1, 0, 0, 1, 0, 0, "resume32");
    // Down through zero and back up across the all-ones boundary.
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 1, "down_to0_32");
    applyStimulus(0, 0, 1, 0, 0, 0, 64'hFFFF_FFFF, 1, 0, "down_wrap32");
    applyStimulus(0, 0, 1, 1, 0, 0, 0, 1, 0, "up_wrap32");
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0, "wrap_clear32");

    // 4-bit full range: tc at 15, wrap pulse on the return to 0.
    applyStimulus(1, 1, 0, 1, 0, 0, 0, 0, 0, "rst4");
    for (int i = 1; i <= 15; i++)
      applyStimulus(1, 0, 1, 1, 0, 0, 64'(i), 0, (i == 15), "cnt4");
    applyStimulus(1, 0, 1, 1, 0, 0, 0, 1, 0, "wrap4");
    applyStimulus(1, 0, 0, 1, 0, 0, 0, 0, 0, "wrap_clear4");

    // Direction toggled every cycle from 5.
    applyStimulus(1, 1, 0, 1, 0, 0, 0, 0, 0, "rst4b");
    for (int i = 1; i <= 5; i++)
      applyStimulus(1, 0, 1, 1, 0, 0, 64'(i), 0, 0, "to5_4");
    applyStimulus(1, 0, 1, 1, 0, 0, 6, 0, 0, "toggle_up_a");
    applyStimulus(1, 0, 1, 0, 0, 0, 5, 0, 0, "toggle_dn_a");
    applyStimulus(1, 0, 1, 1, 0, 0, 6, 0, 0, "toggle_up_b");
    applyStimulus(1, 0, 1, 0, 0, 0, 5, 0, 0, "toggle_dn_b");
    applyStimulus(1, 0, 0, 0, 0, 0, 5, 0, 0, "hold5_4");

    // Modulus 10: down from 0 wraps to 9, up from 9 wraps to 0.
    applyStimulus(2, 1, 0, 1, 0, 0, 0, 0, 0, "rst10");
    applyStimulus(2, 0, 1, 0, 0, 0, 9, 1, 0, "down_wrap10");
    applyStimulus(2, 0, 1, 0, 0, 0, 8, 0, 0, "down8_10");
    applyStimulus(2, 0, 1, 0, 0, 0, 7, 0, 0, "down7_10");
    applyStimulus(2, 0, 1, 1, 0, 0, 8, 0, 0, "up8_10");
    applyStimulus(2, 0, 1, 1, 0, 0, 9, 0, 1, "up9_tc10");
    applyStimulus(2, 0, 1, 1, 0, 0, 0, 1, 0, "up_wrap10");

`ifdef COUNTER_LOAD_EN
    // Modulus 100 with parallel load: in-range, reduced, TOP, and load over a wrap.
    applyStimulus(3, 1, 0, 1, 0, 0, 0, 0, 0, "rst100");
    applyStimulus(3, 0, 1, 1, 1, 64'h37, 64'h37, 0, 0, "load_37");
    applyStimulus(3, 0, 1, 1, 1, 64'd150, 64'd50, 0, 0, "load_150");
    applyStimulus(3, 0, 1, 1, 1, 64'd99, 64'd99, 0, 1, "load_99");
    applyStimulus(3, 0, 1, 1, 0, 0, 0, 1, 0, "wrap100");
    applyStimulus(3, 0, 1, 1, 1, 64'd99, 64'd99, 0, 1, "load_99b");
    applyStimulus(3, 0, 1, 1, 1, 64'd5, 64'd5, 0, 0, "load_over_wrap");
    applyStimulus(3, 0, 1, 1, 1, 64'd100, 64'd0, 0, 0, "load_100");
    applyStimulus(3, 1, 1, 1, 1, 64'd42, 64'd0, 0, 0, "rst_over_load");
`endif

    // Drain the scoreboard with a bounded wait.
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;
    load = 1'b0;
    for (int k = 0; k < 5 && sb.size() > 0; k++)
      @(negedge clk);
    if (sb.size() > 0) begin
      miscompares++;
      $display("[TB] FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
